// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - FP32 field layout, special constants and issue-queue FSM states
package fp_add_pkg;

    localparam int FP32_W = 32;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;

    localparam logic [FP32_W-1:0] FP32_POS_INF = 32'h7F80_0000;
    localparam logic [FP32_W-1:0] FP32_NEG_INF = 32'hFF80_0000;
    localparam logic [FP32_W-1:0] FP32_QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef struct packed {
        fp32_t a;
        fp32_t b;
    } op_pair_t;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wr_en, wr_data      push request (ignored when full)
//   rd_en               pop request (ignored when empty)
//   rd_data             head entry, valid whenever empty=0
//   empty, count        status; count ranges 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end

    // Storage carries no reset: contents are only observed through count/empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fp_add_issue_queue.sv
// rtl/fp_add_issue_queue.sv - credit-gated issue queue in front of a stall-free FP32 adder
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   in_valid/in_ready/in_op_a/b   operand pair input stream
//   add_en/add_op_1/add_op_2      issue strobe and operands to the adder
//   add_res/add_val               result return from the adder
//   out_valid/out_ready/out_res   result output stream (FWFT head)
//   inflight                      issued operations whose result has not returned
//   err_spurious                  sticky flag for a result nobody asked for
module fp_add_issue_queue
    import fp_add_pkg::*;
#(
    parameter int W         = FP32_W,
    parameter int OP_DEPTH  = 4,
    parameter int RES_DEPTH = 8,
    parameter int ADD_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [W-1:0]                in_op_a,
    input  logic [W-1:0]                in_op_b,
    output logic                        add_en,
    output logic [W-1:0]                add_op_1,
    output logic [W-1:0]                add_op_2,
    input  logic [W-1:0]                add_res,
    input  logic                        add_val,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [W-1:0]                out_res,
    output logic [$clog2(RES_DEPTH):0]  inflight,
    output logic                        err_spurious
);

    localparam int CW  = $clog2(RES_DEPTH) + 1;
    localparam int OCW = $clog2(OP_DEPTH) + 1;
    localparam int FW  = $clog2(ADD_LAT + 1) + 1;

    state_t          state_q;
    state_t          state_d;
    logic [FW-1:0]   flush_cnt;
    logic            run;

    logic [2*W-1:0]  op_head;
    logic            op_empty;
    logic [OCW-1:0]  op_count;
    logic            op_push;

    logic            res_empty;
    logic [CW-1:0]   res_count;

    logic [CW:0]     credit_used;
    logic            issue;
    logic            ret;
    logic            spur;

    // FLUSH covers the cycles in which the adder may still emit results for
    // operations issued before reset; those must not be counted or flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FLUSH;
            flush_cnt <= FW'(ADD_LAT);
        end else begin
            state_q <= state_d;
            if (state_q == ST_FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - FW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_FLUSH && flush_cnt == '0) state_d = ST_RUN;
    end

    assign run = (state_q == ST_RUN);

    assign in_ready = !reset && run && (op_count < OCW'(OP_DEPTH));
    assign op_push  = in_valid && in_ready;

    sync_fifo #(
        .WIDTH (2*W),
        .DEPTH (OP_DEPTH)
    ) u_op_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (op_push),
        .wr_data ({in_op_a, in_op_b}),
        .rd_en   (issue),
        .rd_data (op_head),
        .empty   (op_empty),
        .count   (op_count)
    );

    // Every issued op owns a result-FIFO slot until it is popped, so the
    // adder can never return a result with nowhere to put it.
    assign credit_used = {1'b0, res_count} + {1'b0, inflight};
    assign issue       = run && !op_empty && (credit_used < (CW+1)'(RES_DEPTH));
    assign ret         = add_val && (inflight != '0);
    assign spur        = add_val && (inflight == '0) && run;

    always_ff @(posedge clk) begin
        if (reset) begin
            add_en   <= 1'b0;
            add_op_1 <= '0;
            add_op_2 <= '0;
        end else begin
            add_en <= issue;
            if (issue) begin
                add_op_1 <= op_head[2*W-1:W];
                add_op_2 <= op_head[W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else if (issue && !ret) begin
            inflight <= inflight + CW'(1);
        end else if (!issue && ret) begin
            inflight <= inflight - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_spurious <= 1'b0;
        end else if (spur) begin
            err_spurious <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ret),
        .wr_data (add_res),
        .rd_en   (out_ready),
        .rd_data (out_res),
        .empty   (res_empty),
        .count   (res_count)
    );

    assign out_valid = !res_empty;

    a_no_res_overflow: assert property (@(posedge clk) disable iff (reset)
        !(ret && res_count == CW'(RES_DEPTH)));

endmodule
